// File: rtl/ysyx_22040088_id_stage.sv
// Decode stage: opcode classification, immediate generation, register file with
// optional writeback bypass, busy scoreboard for RAW/WAW stalls, one-entry output register.
module ysyx_22040088_id_stage #(
  parameter int XLEN      = 64,
  parameter int RF_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_rf_we,
  output logic [2:0]      out_itype,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            hazard
);
  typedef enum logic [2:0] {
    IT_R = 3'd0, IT_I = 3'd1, IT_S = 3'd2, IT_B = 3'd3,
    IT_U = 3'd4, IT_J = 3'd5, IT_ILL = 3'd7
  } itype_e;

  itype_e          itype;
  logic [63:0]     imm64;
  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2, rf_we, accept, wb_live;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] rf [32];
  logic [31:0]     busy, busy_eff, busy_nxt;

  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign rd  = in_inst[11:7];

  always_comb begin
    case (in_inst[6:0])
      7'b0110011, 7'b0111011:                         itype = IT_R;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: itype = IT_I;
      7'b0100011:                                     itype = IT_S;
      7'b1100011:                                     itype = IT_B;
      7'b0110111, 7'b0010111:                         itype = IT_U;
      7'b1101111:                                     itype = IT_J;
      default:                                        itype = IT_ILL;
    endcase
  end

  // Built at 64 bits and truncated so one expression serves both XLEN values.
  always_comb begin
    case (itype)
      IT_I:    imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
      IT_S:    imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      IT_B:    imm64 = {{52{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      IT_U:    imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
      IT_J:    imm64 = {{44{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      default: imm64 = 64'd0;
    endcase
  end

  assign use_rs1 = (itype == IT_R) || (itype == IT_I) || (itype == IT_S) || (itype == IT_B);
  assign use_rs2 = (itype == IT_R) || (itype == IT_S) || (itype == IT_B);
  assign rf_we   = ((itype == IT_R) || (itype == IT_I) || (itype == IT_U) || (itype == IT_J))
                   && (rd != 5'd0);

  // A same-cycle writeback both forwards its data and retires its busy bit.
  assign wb_live  = (RF_BYPASS != 0) && wb_en && (wb_addr != 5'd0);
  assign busy_eff = wb_live ? (busy & ~(32'd1 << wb_addr)) : busy;

  always_comb begin
    rs1_data = rf[rs1];
    if (rs1 == 5'd0)                       rs1_data = '0;
    else if (wb_live && (wb_addr == rs1))  rs1_data = wb_data;
    rs2_data = rf[rs2];
    if (rs2 == 5'd0)                       rs2_data = '0;
    else if (wb_live && (wb_addr == rs2))  rs2_data = wb_data;
  end

  assign hazard   = (use_rs1 && busy_eff[rs1]) || (use_rs2 && busy_eff[rs2])
                    || (rf_we && busy_eff[rd]);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Ordering matters: the accept-side set overrides any clear of the same bit.
  always_comb begin
    busy_nxt = busy;
    if (wb_en && (wb_addr != 5'd0))       busy_nxt[wb_addr] = 1'b0;
    if (flush && out_valid && out_rf_we)  busy_nxt[out_rd]  = 1'b0;
    if (accept && rf_we)                  busy_nxt[rd]      = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      busy <= busy_nxt;
      if (wb_en && (wb_addr != 5'd0)) rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_inst     <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_rf_we    <= 1'b0;
      out_itype    <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_pc       <= in_pc;
        out_inst     <= in_inst;
        out_rs1_data <= rs1_data;
        out_rs2_data <= rs2_data;
        out_imm      <= imm64[XLEN-1:0];
        out_rd       <= rd;
        out_rf_we    <= rf_we;
        out_itype    <= itype;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22040088_id_stage.sv
// Directed bench for the decode stage; expected outputs queue up at accept and
// are compared on each handoff.
module tb_ysyx_22040088_id_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1, wb_en = 1'b0, flush = 1'b0;
  logic [63:0] in_pc = '0, wb_data = '0;
  logic [31:0] in_inst = '0;
  logic [4:0]  wb_addr = '0;

  logic        in_ready, out_valid, out_rf_we, hazard;
  logic [63:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [31:0] out_inst;
  logic [4:0]  out_rd;
  logic [2:0]  out_itype;

  logic        in_ready_32, out_valid_32, out_rf_we_32, hazard_32;
  logic [31:0] out_pc_32, out_rs1_32, out_rs2_32, out_imm_32, out_inst_32;
  logic [4:0]  out_rd_32;
  logic [2:0]  out_itype_32;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  it;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] r1, r2;
    bit          chk_rs;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  always #5 clk = ~clk;

  ysyx_22040088_id_stage #(.XLEN(64), .RF_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd(out_rd), .out_rf_we(out_rf_we), .out_itype(out_itype),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .hazard(hazard)
  );

  ysyx_22040088_id_stage #(.XLEN(32), .RF_BYPASS(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32), .in_pc(in_pc[31:0]),
    .in_inst(in_inst), .out_valid(out_valid_32), .out_ready(out_ready), .out_pc(out_pc_32),
    .out_inst(out_inst_32), .out_rs1_data(out_rs1_32), .out_rs2_data(out_rs2_32),
    .out_imm(out_imm_32), .out_rd(out_rd_32), .out_rf_we(out_rf_we_32),
    .out_itype(out_itype_32), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data[31:0]),
    .flush(flush), .hazard(hazard_32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic exp_t mk(input logic [31:0] inst, input logic [63:0] pc,
                              input logic [63:0] imm, input logic [2:0] it, input logic [4:0] rd,
                              input logic we, input logic [63:0] r1, input logic [63:0] r2,
                              input bit chk_rs);
    exp_t e;
    e.inst = inst; e.pc = pc; e.imm = imm; e.it = it; e.rd = rd; e.we = we;
    e.r1 = r1; e.r2 = r2; e.chk_rs = chk_rs;
    return e;
  endfunction

  // Present an instruction until accepted (bounded); leaves at posedge+1 after accept.
  task automatic issue(input exp_t e);
    bit done = 0;
    in_valid = 1'b1; in_inst = e.inst; in_pc = e.pc;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin sb.push_back(e); done = 1; end
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  // Handoff monitor: outputs are stable at the negedge preceding the handoff edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) chk("sb_empty", 64'd0, 64'd1);
      else begin
        m = sb.pop_front();
        chk("out_pc", out_pc, m.pc);
        chk("out_inst", {32'd0, out_inst}, {32'd0, m.inst});
        chk("out_imm", out_imm, m.imm);
        chk("out_itype", {61'd0, out_itype}, {61'd0, m.it});
        chk("out_rd", {59'd0, out_rd}, {59'd0, m.rd});
        chk("out_rf_we", {63'd0, out_rf_we}, {63'd0, m.we});
        if (m.chk_rs) begin
          chk("out_rs1_data", out_rs1_data, m.r1);
          chk("out_rs2_data", out_rs2_data, m.r2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s_pc, s_imm;
    logic [31:0] s_inst;
    logic [7:0]  s_misc;
    exp_t tbl[4];

    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_itype", {61'd0, out_itype}, 64'd0);
    chk("rst_out_rf_we", {63'd0, out_rf_we}, 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_busy", {32'd0, dut.busy}, 64'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // addi x1,x0,5
    issue(mk(32'h00500093, 64'h80000000, 64'd5, 3'd1, 5'd1, 1'b1, 64'd0, 64'd0, 1));
    chk("addi_out_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_busy1", {63'd0, dut.busy[1]}, 64'd1);

    // add x2,x1,x1: stalls until x1 writes back, then takes the forwarded value
    in_valid = 1'b1; in_inst = 32'h00108133; in_pc = 64'h80000004;
    @(negedge clk);
    chk("raw_hazard", {63'd0, hazard}, 64'd1);
    chk("raw_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'd5;
    issue(mk(32'h00108133, 64'h80000004, 64'd0, 3'd0, 5'd2, 1'b1, 64'd5, 64'd5, 1));
    wb_en = 1'b0;
    chk("wb_busy1_clr", {63'd0, dut.busy[1]}, 64'd0);
    chk("add_busy2", {63'd0, dut.busy[2]}, 64'd1);
    tick();

    // beq x0,x0,-4 held for 3 cycles by out_ready=0
    out_ready = 1'b0;
    issue(mk(32'hFE000EE3, 64'h80000008, 64'hFFFFFFFFFFFFFFFC, 3'd3, 5'd29, 1'b0, 64'd0, 64'd0, 1));
    chk("beq_imm32", {32'd0, out_imm_32}, 64'h00000000FFFFFFFC);
    s_pc = out_pc; s_imm = out_imm; s_inst = out_inst;
    s_misc = {out_valid, out_rf_we, out_itype, 3'd0};
    in_valid = 1'b1; in_inst = 32'h00700193; in_pc = 64'h8000000C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_pc", out_pc, s_pc);
      chk("stall_imm", out_imm, s_imm);
      chk("stall_inst", {32'd0, out_inst}, {32'd0, s_inst});
      chk("stall_misc", {56'd0, out_valid, out_rf_we, out_itype, 3'd0}, {56'd0, s_misc});
      tick();
    end
    out_ready = 1'b1;
    issue(mk(32'h00700193, 64'h8000000C, 64'd7, 3'd1, 5'd3, 1'b1, 64'd0, 64'd0, 1));
    out_ready = 1'b0;
    chk("addi3_busy3", {63'd0, dut.busy[3]}, 64'd1);

    // flush the held addi x3
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_busy3", {63'd0, dut.busy[3]}, 64'd0);
    out_ready = 1'b1;
    in_inst = 32'h00018233;
    @(negedge clk);
    chk("post_flush_hazard", {63'd0, hazard}, 64'd0);
    tick();
    issue(mk(32'h00018233, 64'h80000010, 64'd0, 3'd0, 5'd4, 1'b1, 64'd0, 64'd0, 1));
    tick();

    // reset in the middle of a held addi x5
    out_ready = 1'b0;
    issue(mk(32'h00900293, 64'h80000014, 64'd9, 3'd1, 5'd5, 1'b1, 64'd0, 64'd0, 1));
    chk("pre_rst_busy5", {63'd0, dut.busy[5]}, 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_busy", {32'd0, dut.busy}, 64'd0);
    chk("rst_mid_rf1", dut.rf[1], 64'd0);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    tick();

    // x1 was cleared by reset
    issue(mk(32'h00108333, 64'h80000018, 64'd0, 3'd0, 5'd6, 1'b1, 64'd0, 64'd0, 1));
    tbl[0] = mk(32'h123452B7, 64'h8000001C, 64'h0000000012345000, 3'd4, 5'd5, 1'b1, 64'd0, 64'd0, 0);
    tbl[1] = mk(32'h0080006F, 64'h80000020, 64'd8, 3'd5, 5'd0, 1'b0, 64'd0, 64'd0, 0);
    tbl[2] = mk(32'hFE002C23, 64'h80000024, 64'hFFFFFFFFFFFFFFF8, 3'd2, 5'd24, 1'b0, 64'd0, 64'd0, 1);
    tbl[3] = mk(32'h0000007F, 64'h80000028, 64'd0, 3'd7, 5'd0, 1'b0, 64'd0, 64'd0, 0);
    foreach (tbl[i]) issue(tbl[i]);
    repeat (3) tick();
    chk("sb_drain", {32'd0, sb.size()}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
